// File: rtl/comp_tracker_mp.sv
// comp_tracker_mp
//   Accumulates per-antenna, per-polarisation component sums
//   SP = sum(re+im) and SM = sum(re-im) over 2^ACC_LEN_BITS passes of an
//   antenna-multiplexed stream into a double-buffered store. It then serves
//   baseline-pair correction lookups from the completed (read) bank.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   sync       : marks ant 0 / pass 0; only looked at when din_vld=1
//   din_vld    : input beat valid
//   din        : N_POLS * 2^P_FACTOR_BITS complex samples (re above im)
//   rd_en      : correction lookup request
//   rd_ant_a/b : baseline antennas (pol p taken from a, pol q from b)
//   re_corr    : SP_p(a)+SP_q(b) per (p,q), slice (p*N_POLS+q)*CW
//   im_corr    : SM_q(b)-SM_p(a) per (p,q), same slicing
//   corr_vld   : lookup result valid
//   acc_done   : one-cycle pulse when a bank completes
//   bank_valid : a completed bank is readable
//   sync_err   : sticky misaligned-sync flag
//
// Build option
//   COMP_TRACKER_MP_OUT_REG_EN : adds an output register on the lookup
//   path (latency 3 instead of 2).
module comp_tracker_mp #(
    parameter int N_ANTS        = 32,
    parameter int N_POLS        = 2,
    parameter int P_FACTOR_BITS = 2,
    parameter int BITWIDTH      = 4,
    parameter int ACC_LEN_BITS  = 7,
    localparam int ANT_BITS = (N_ANTS > 1) ? $clog2(N_ANTS) : 1,
    localparam int SUM_W    = BITWIDTH + 1 + P_FACTOR_BITS,
    localparam int ACC_W    = SUM_W + ACC_LEN_BITS,
    localparam int CW       = ACC_W + 1,
    localparam int NSAMP    = 1 << P_FACTOR_BITS,
    localparam int DIN_W    = N_POLS * NSAMP * 2 * BITWIDTH,
    localparam int OUT_W    = N_POLS * N_POLS * CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic                din_vld,
    input  logic [DIN_W-1:0]    din,
    input  logic                rd_en,
    input  logic [ANT_BITS-1:0] rd_ant_a,
    input  logic [ANT_BITS-1:0] rd_ant_b,
    output logic [OUT_W-1:0]    re_corr,
    output logic [OUT_W-1:0]    im_corr,
    output logic                corr_vld,
    output logic                acc_done,
    output logic                bank_valid,
    output logic                sync_err
);

    typedef enum logic {IDLE, ACC} state_e;

    state_e                  state_q, state_d;
    logic [ANT_BITS-1:0]     ant_q, ant_d, cur_ant;
    logic [ACC_LEN_BITS-1:0] pass_q, pass_d, cur_pass;
    logic                    sync_err_q, sync_err_d;
    logic                    beat_ok, last_ant;

    // ---------------- position tracking FSM ----------------
    always_comb begin
        state_d    = state_q;
        ant_d      = ant_q;
        pass_d     = pass_q;
        sync_err_d = sync_err_q;
        beat_ok    = 1'b0;
        cur_ant    = ant_q;
        cur_pass   = pass_q;
        case (state_q)
            IDLE: begin
                if (din_vld && sync) begin
                    state_d  = ACC;
                    beat_ok  = 1'b1;
                    cur_ant  = '0;
                    cur_pass = '0;
                end
            end
            ACC: begin
                if (din_vld) begin
                    beat_ok = 1'b1;
                    // Sync anywhere but the wrap position restarts the
                    // same write bank; pass-0 overwrite discards the partial.
                    if (sync && (ant_q != '0 || pass_q != '0)) begin
                        sync_err_d = 1'b1;
                        cur_ant    = '0;
                        cur_pass   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last_ant = (cur_ant == ANT_BITS'(N_ANTS - 1));
        if (beat_ok) begin
            ant_d  = last_ant ? '0 : cur_ant + 1'b1;
            pass_d = last_ant ? cur_pass + 1'b1 : cur_pass;
        end
    end

    // ---------------- per-beat component sums ----------------
    logic signed [SUM_W-1:0] sp_c [N_POLS];
    logic signed [SUM_W-1:0] sm_c [N_POLS];

    always_comb begin
        for (int p = 0; p < N_POLS; p++) begin
            sp_c[p] = '0;
            sm_c[p] = '0;
            for (int i = 0; i < NSAMP; i++) begin
                sp_c[p] = sp_c[p]
                        + SUM_W'($signed(din[((i*N_POLS+p)*2+1)*BITWIDTH +: BITWIDTH]))
                        + SUM_W'($signed(din[((i*N_POLS+p)*2)*BITWIDTH +: BITWIDTH]));
                sm_c[p] = sm_c[p]
                        + SUM_W'($signed(din[((i*N_POLS+p)*2+1)*BITWIDTH +: BITWIDTH]))
                        - SUM_W'($signed(din[((i*N_POLS+p)*2)*BITWIDTH +: BITWIDTH]));
            end
        end
    end

    // ---------------- stage 1: registered sums ----------------
    logic                    s1_vld_q, s1_first_q, s1_last_q;
    logic [ANT_BITS-1:0]     s1_ant_q;
    logic signed [SUM_W-1:0] s1_sp_q [N_POLS];
    logic signed [SUM_W-1:0] s1_sm_q [N_POLS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ant_q      <= '0;
            pass_q     <= '0;
            sync_err_q <= 1'b0;
            s1_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ant_q      <= ant_d;
            pass_q     <= pass_d;
            sync_err_q <= sync_err_d;
            s1_vld_q   <= beat_ok;
        end
    end

    always_ff @(posedge clk) begin
        s1_ant_q   <= cur_ant;
        s1_first_q <= (cur_pass == '0);
        s1_last_q  <= last_ant && (&cur_pass);
        s1_sp_q    <= sp_c;
        s1_sm_q    <= sm_c;
    end

    // ---------------- stage 2: bank store and swap ----------------
    logic signed [ACC_W-1:0] sp_mem [2][N_ANTS][N_POLS];
    logic signed [ACC_W-1:0] sm_mem [2][N_ANTS][N_POLS];
    logic                    wr_ptr_q, rd_ptr_q, acc_done_q, bank_valid_q;

    always_ff @(posedge clk) begin
        if (!rst && s1_vld_q) begin
            for (int p = 0; p < N_POLS; p++) begin
                sp_mem[wr_ptr_q][s1_ant_q][p] <= s1_first_q ? ACC_W'(s1_sp_q[p])
                    : sp_mem[wr_ptr_q][s1_ant_q][p] + ACC_W'(s1_sp_q[p]);
                sm_mem[wr_ptr_q][s1_ant_q][p] <= s1_first_q ? ACC_W'(s1_sm_q[p])
                    : sm_mem[wr_ptr_q][s1_ant_q][p] + ACC_W'(s1_sm_q[p]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            acc_done_q   <= 1'b0;
            bank_valid_q <= 1'b0;
        end else begin
            acc_done_q <= 1'b0;
            if (s1_vld_q && s1_last_q) begin
                rd_ptr_q     <= wr_ptr_q;
                wr_ptr_q     <= ~wr_ptr_q;
                acc_done_q   <= 1'b1;
                bank_valid_q <= 1'b1;
            end
        end
    end

    // ---------------- lookup: fetch in the rd_en cycle ----------------
    // Fetching straight away pins the lookup to the bank that is readable
    // in the request cycle, so a later swap cannot disturb it.
    logic                    lu_vld_q;
    logic signed [ACC_W-1:0] lu_spa_q [N_POLS];
    logic signed [ACC_W-1:0] lu_sma_q [N_POLS];
    logic signed [ACC_W-1:0] lu_spb_q [N_POLS];
    logic signed [ACC_W-1:0] lu_smb_q [N_POLS];

    always_ff @(posedge clk) begin
        if (rst) lu_vld_q <= 1'b0;
        else     lu_vld_q <= rd_en && bank_valid_q;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < N_POLS; p++) begin
            lu_spa_q[p] <= sp_mem[rd_ptr_q][rd_ant_a][p];
            lu_sma_q[p] <= sm_mem[rd_ptr_q][rd_ant_a][p];
            lu_spb_q[p] <= sp_mem[rd_ptr_q][rd_ant_b][p];
            lu_smb_q[p] <= sm_mem[rd_ptr_q][rd_ant_b][p];
        end
    end

    logic [OUT_W-1:0] re_d, im_d;

    always_comb begin
        re_d = '0;
        im_d = '0;
        for (int p = 0; p < N_POLS; p++) begin
            for (int q = 0; q < N_POLS; q++) begin
                re_d[(p*N_POLS+q)*CW +: CW] = CW'(lu_spa_q[p]) + CW'(lu_spb_q[q]);
                im_d[(p*N_POLS+q)*CW +: CW] = CW'(lu_smb_q[q]) - CW'(lu_sma_q[p]);
            end
        end
    end

    // Data is forced to zero whenever the result is not valid.
    logic             o_vld_q;
    logic [OUT_W-1:0] o_re_q, o_im_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld_q <= 1'b0;
            o_re_q  <= '0;
            o_im_q  <= '0;
        end else begin
            o_vld_q <= lu_vld_q;
            o_re_q  <= lu_vld_q ? re_d : '0;
            o_im_q  <= lu_vld_q ? im_d : '0;
        end
    end

`ifdef COMP_TRACKER_MP_OUT_REG_EN
    logic             o2_vld_q;
    logic [OUT_W-1:0] o2_re_q, o2_im_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o2_vld_q <= 1'b0;
            o2_re_q  <= '0;
            o2_im_q  <= '0;
        end else begin
            o2_vld_q <= o_vld_q;
            o2_re_q  <= o_re_q;
            o2_im_q  <= o_im_q;
        end
    end

    assign corr_vld = o2_vld_q;
    assign re_corr  = o2_re_q;
    assign im_corr  = o2_im_q;
`else
    assign corr_vld = o_vld_q;
    assign re_corr  = o_re_q;
    assign im_corr  = o_im_q;
`endif

    assign acc_done   = acc_done_q;
    assign bank_valid = bank_valid_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_comp_tracker_mp.sv
// Directed bench for comp_tracker_mp with the small test configuration
// (4 ants, 2 pols, 2 samples/beat, 4-bit parts, 4 passes; CW = 9).
module tb_comp_tracker_mp;
    localparam int N_ANTS = 4;
    localparam int N_POLS = 2;
    localparam int PF     = 1;
    localparam int BW     = 4;
    localparam int ALB    = 2;
    localparam int NS     = 2;
    localparam int DIN_W  = N_POLS * NS * 2 * BW;
    localparam int CW     = 9;
    localparam int NPP    = N_POLS * N_POLS;
`ifdef COMP_TRACKER_MP_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               rst, sync, din_vld, rd_en;
    logic [DIN_W-1:0]   din;
    logic [1:0]         rd_ant_a, rd_ant_b;
    logic [NPP*CW-1:0]  re_corr, im_corr;
    logic               corr_vld, acc_done, bank_valid, sync_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comp_tracker_mp #(
        .N_ANTS(N_ANTS), .N_POLS(N_POLS), .P_FACTOR_BITS(PF),
        .BITWIDTH(BW), .ACC_LEN_BITS(ALB)
    ) dut (
        .clk(clk), .rst(rst), .sync(sync), .din_vld(din_vld), .din(din),
        .rd_en(rd_en), .rd_ant_a(rd_ant_a), .rd_ant_b(rd_ant_b),
        .re_corr(re_corr), .im_corr(im_corr), .corr_vld(corr_vld),
        .acc_done(acc_done), .bank_valid(bank_valid), .sync_err(sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] cwv(input int v);
        logic [CW-1:0] t;
        t = CW'(v);
        return {{(32-CW){1'b0}}, t};
    endfunction

    // Same value on every sample of a pol.
    function automatic logic [DIN_W-1:0] mk(input int re0, input int im0, input int re1, input int im1);
        logic [DIN_W-1:0] d;
        d = '0;
        for (int i = 0; i < NS; i++) begin
            for (int p = 0; p < N_POLS; p++) begin
                d[((i*N_POLS+p)*2+1)*BW +: BW] = BW'(p == 0 ? re0 : re1);
                d[((i*N_POLS+p)*2)*BW +: BW]   = BW'(p == 0 ? im0 : im1);
            end
        end
        return d;
    endfunction

    task automatic beat(input logic s, input logic [DIN_W-1:0] d);
        din_vld = 1'b1; sync = s; din = d;
        @(negedge clk);
        din_vld = 1'b0; sync = 1'b0; din = '0;
    endtask

    // Idle beat carrying sync and junk: must be ignored entirely.
    task automatic gap();
        din_vld = 1'b0; sync = 1'b1; din = mk(7, 7, 7, 7);
        @(negedge clk);
        sync = 1'b0; din = '0;
    endtask

    // mode 0: re=1 im=0; 1: ant-dependent; 2: re=im=-8
    task automatic run16(input string tag, input int mode, input bit gaps);
        logic [DIN_W-1:0] d;
        for (int j = 0; j < 16; j++) begin
            case (mode)
                0:       d = mk(1, 0, 1, 0);
                1:       d = mk(j % N_ANTS, 1, 0, -1);
                default: d = mk(-8, -8, -8, -8);
            endcase
            beat(j == 0, d);
            if (gaps && j != 15) gap();
        end
        chk({tag, " acc_done early"}, 32'(acc_done), 32'd0);
        @(negedge clk);
        chk({tag, " acc_done"}, 32'(acc_done), 32'd1);
        chk({tag, " bank_valid"}, 32'(bank_valid), 32'd1);
        @(negedge clk);
        chk({tag, " acc_done pulse end"}, 32'(acc_done), 32'd0);
    endtask

    task automatic lookup(input string tag, input int a, input int b,
                          input int r00, input int r01, input int r10, input int r11,
                          input int i00, input int i01, input int i10, input int i11);
        int r[4];
        int m[4];
        r = '{r00, r01, r10, r11};
        m = '{i00, i01, i10, i11};
        rd_en = 1'b1; rd_ant_a = 2'(a); rd_ant_b = 2'(b);
        @(negedge clk);
        rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk({tag, " corr_vld early"}, 32'(corr_vld), 32'd0);
            @(negedge clk);
        end
        chk({tag, " corr_vld"}, 32'(corr_vld), 32'd1);
        for (int k = 0; k < NPP; k++) begin
            chk($sformatf("%s re%0d", tag, k), {{(32-CW){1'b0}}, re_corr[k*CW +: CW]}, cwv(r[k]));
            chk($sformatf("%s im%0d", tag, k), {{(32-CW){1'b0}}, im_corr[k*CW +: CW]}, cwv(m[k]));
        end
        @(negedge clk);
        chk({tag, " corr_vld drop"}, 32'(corr_vld), 32'd0);
    endtask

    // Lookup that must never produce a valid result or nonzero data.
    task automatic dead_lookup(input string tag);
        rd_en = 1'b1; rd_ant_a = 2'd1; rd_ant_b = 2'd2;
        @(negedge clk);
        rd_en = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            chk({tag, " corr_vld"}, 32'(corr_vld), 32'd0);
            chk({tag, " re zero"}, 32'(|re_corr), 32'd0);
            chk({tag, " im zero"}, 32'(|im_corr), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; din_vld = 1'b0; din = '0;
        rd_en = 1'b0; rd_ant_a = '0; rd_ant_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst corr_vld", 32'(corr_vld), 32'd0);
        chk("rst acc_done", 32'(acc_done), 32'd0);
        chk("rst bank_valid", 32'(bank_valid), 32'd0);
        chk("rst sync_err", 32'(sync_err), 32'd0);
        chk("rst re zero", 32'(|re_corr), 32'd0);
        chk("rst im zero", 32'(|im_corr), 32'd0);
        dead_lookup("no bank");

        // test 1: re=1 im=0
        run16("t1", 0, 1'b0);
        lookup("t1", 0, 2, 16, 16, 16, 16, 0, 0, 0, 0);

        // test 2: ant-dependent; sync lands on the wrap position
        run16("t2", 1, 1'b0);
        chk("t2 sync_err", 32'(sync_err), 32'd0);
        lookup("t2 (1,3)", 1, 3, 48, 8, 24, -16, 16, 8, 8, 0);
        lookup("t2 (2,2)", 2, 2, 48, 16, 16, -16, 0, 0, 0, 0);

        // test 3: most negative input, no wrap
        run16("t3", 2, 1'b0);
        lookup("t3", 0, 3, -256, -256, -256, -256, 0, 0, 0, 0);

        // test 4: test 1 with idle beats carrying sync
        run16("t4", 0, 1'b1);
        chk("t4 sync_err", 32'(sync_err), 32'd0);
        lookup("t4", 1, 2, 16, 16, 16, 16, 0, 0, 0, 0);

        // test 5: misaligned sync at beat 6
        for (int j = 0; j < 6; j++) beat(j == 0, mk(7, 0, 7, 0));
        beat(1'b1, mk(2, 0, 2, 0));
        chk("t5 sync_err", 32'(sync_err), 32'd1);
        chk("t5 bank_valid kept", 32'(bank_valid), 32'd1);
        lookup("t5 old bank", 0, 1, 16, 16, 16, 16, 0, 0, 0, 0);
        for (int j = 1; j < 16; j++) begin
            beat(1'b0, mk(2, 0, 2, 0));
            chk("t5 no acc_done", 32'(acc_done), 32'd0);
        end
        @(negedge clk);
        chk("t5 acc_done", 32'(acc_done), 32'd1);
        @(negedge clk);
        chk("t5 acc_done pulse end", 32'(acc_done), 32'd0);
        chk("t5 sync_err sticky", 32'(sync_err), 32'd1);
        lookup("t5 new bank", 3, 0, 32, 32, 32, 32, 0, 0, 0, 0);

        // test 6: reset in the cycle after rd_en
        rd_en = 1'b1; rd_ant_a = 2'd0; rd_ant_b = 2'd0;
        @(negedge clk);
        rd_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < LAT + 1; k++) begin
            chk("t6 corr_vld", 32'(corr_vld), 32'd0);
            chk("t6 re zero", 32'(|re_corr), 32'd0);
            chk("t6 im zero", 32'(|im_corr), 32'd0);
            chk("t6 bank_valid", 32'(bank_valid), 32'd0);
            chk("t6 sync_err", 32'(sync_err), 32'd0);
            chk("t6 acc_done", 32'(acc_done), 32'd0);
            @(negedge clk);
        end
        dead_lookup("t6 after rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
